mem_sequencer: RTL
==================

Name: mem_sequencer

Overview:
- Initiator-side access sequencer for the banked AGC-style memory: accepts CPU-side requests over a valid/ready handshake and drives the memory's bank/address/data/write-enable inputs.
- Memory read is combinational from the resolved address; write commits at posedge clk.
- Supports single- and double-precision read, write and exchange (XCH/DXCH).
- Returns read data and error status on a one-cycle response strobe.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, word width.
- FIXED_BASE, 12'h400, first fixed-memory (read-only) address; writes at or above it are rejected.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  3  0 READ, 1 WRITE, 2 DREAD, 3 DWRITE, 4 XCH, 5 DXCH, 6-7 illegal
- req_addr  in  ADDR_W  word address (double ops: hi word at addr, lo at addr+1)
- req_ebank  in  3  erasable bank
- req_fbank  in  5  fixed bank
- req_super  in  1  superbank bit
- req_wdata_hi  in  DATA_W  write data, hi/single word
- req_wdata_lo  in  DATA_W  write data, lo word
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  request rejected, valid with rsp_valid
- rsp_rdata_hi  out  DATA_W  read/old data, hi/single word
- rsp_rdata_lo  out  DATA_W  read/old data, lo word (0 for single ops)
- mem_ebank  out  3  to memory eBank
- mem_fbank  out  5  to memory fBank
- mem_super  out  1  to memory superBank
- mem_address  out  ADDR_W  to memory memAddress
- mem_data_out  out  DATA_W  to memory dataIn
- mem_write_enable  out  1  to memory writeEnable
- mem_result  in  DATA_W  from memory result (combinational read)

Behaviour:
- States: IDLE, ACC_HI, ACC_LO, RESP.
- Reset (async, active-high): state IDLE; all outputs 0, including req_ready, rsp_valid and mem_write_enable. req_ready rises in the first cycle after reset deasserts.
- IDLE:
  - req_ready=1. Accept on posedge when req_valid&&req_ready; latch op, addr, banks and wdata.
  - Next state ACC_HI, or RESP with error if the request is illegal.
- Error conditions (no memory access; rsp_err=1, rdata=0):
  - op 6/7.
  - Double op with addr==all-ones (no wrap to 0).
  - Write/XCH/DWRITE/DXCH where any touched address >= FIXED_BASE.
- ACC_HI:
  - mem_address=addr; mem_data_out=wdata_hi.
  - mem_write_enable=1 for WRITE/DWRITE/XCH/DXCH.
  - rsp_rdata_hi captures mem_result at the edge. For XCH this is the old value: combinational read precedes the write edge.
  - Next state ACC_LO for double ops, else RESP.
- ACC_LO:
  - mem_address=addr+1, same banks; mem_data_out=wdata_lo; we as in ACC_HI.
  - rsp_rdata_lo captures mem_result.
  - Next state RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err and rdata stable while rsp_valid.
  - Next state IDLE. No back-pressure on the response.
- Latency (accept edge to rsp_valid high): single op 2 cycles, double 3, error 1. Throughput: one request per 3 (single) / 4 (double) cycles.
- req_ready=0 outside IDLE. Requests presented then are held by the requester, not dropped.
- mem_write_enable is decoded from the state register only, so async reset drops it immediately. It is never high in IDLE or RESP.
- Memory-side address, bank and data outputs hold their last values between accesses. Only mem_write_enable returns to 0.
- Reset mid-operation: transaction abandoned, no rsp_valid. A write already committed on a previous edge stays committed (DWRITE may be half-done).
- Banks pass through unchanged; bank resolution stays in the memory's address logic.
- Writes to addresses 0-10 are permitted. The memory's register mirror overwrites them each cycle; not the sequencer's concern.

Decomposition:
- Shared package mem_seq_pkg: op codes, state encoding, FIXED_BASE, ADDR_W/DATA_W defaults.
- No sub-module warranted; the error check is a small combinational function inside mem_sequencer.

Test Plan:
- READ addr 12'h030, ebank 3, memory preloaded 16'h1234 -> rsp_valid 2 cycles after accept, rdata_hi=16'h1234, rdata_lo=0, err=0, mem_write_enable never high.
- DWRITE addr 12'h040, hi=16'hAAAA, lo=16'h5555, then DREAD 12'h040 -> we high exactly 2 cycles; DREAD returns hi=16'hAAAA, lo=16'h5555 after 3 cycles.
- XCH addr 12'h050 (old 16'h0007), wdata_hi=16'h0100 -> rdata_hi=16'h0007; subsequent READ returns 16'h0100.
- WRITE addr 12'h400 and DREAD addr 12'hFFF and op 6 -> each rsp_valid 1 cycle after accept, err=1, rdata=0, no write strobe, memory unchanged.
- Back-to-back: req_valid held high with two READs -> second accepted only after RESP (req_ready low 2 cycles), both responses correct.
- Assert reset during DWRITE ACC_LO -> mem_write_enable drops same cycle; no rsp_valid; hi word written, lo word unchanged; req_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer: opcodes, FSM states,
// default widths and the opcode classification helpers.
package mem_seq_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 16;
  localparam int FIXED_BASE_DEF = 'h400;

  typedef enum logic [2:0] {
    OP_READ   = 3'd0,
    OP_WRITE  = 3'd1,
    OP_DREAD  = 3'd2,
    OP_DWRITE = 3'd3,
    OP_XCH    = 3'd4,
    OP_DXCH   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC_HI,
    ST_ACC_LO,
    ST_RESP
  } state_e;

  function automatic logic op_is_double(input logic [2:0] op);
    return (op == OP_DREAD) || (op == OP_DWRITE) || (op == OP_DXCH);
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_WRITE) || (op == OP_DWRITE) || (op == OP_XCH) || (op == OP_DXCH);
  endfunction

endpackage

// File: rtl/mem_sequencer.sv
// Sequences single/double read, write and exchange requests onto the banked
// memory port; returns read (or pre-write) data on a one-cycle response strobe.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] FIXED_BASE = ADDR_W'(FIXED_BASE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_ebank,
  input  logic [4:0]        req_fbank,
  input  logic              req_super,
  input  logic [DATA_W-1:0] req_wdata_hi,
  input  logic [DATA_W-1:0] req_wdata_lo,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata_hi,
  output logic [DATA_W-1:0] rsp_rdata_lo,
  output logic [2:0]        mem_ebank,
  output logic [4:0]        mem_fbank,
  output logic              mem_super,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_result
);

  // A double op at the top address would wrap to 0, so it is rejected; writes
  // must keep every touched word below the fixed (read-only) region.
  function automatic logic req_illegal(input logic [2:0] op, input logic [ADDR_W-1:0] addr);
    logic              dbl;
    logic [ADDR_W:0]   last;
    dbl  = op_is_double(op);
    last = {1'b0, addr} + (ADDR_W+1)'(dbl);
    if (op > OP_DXCH)                                     return 1'b1;
    if (dbl && (&addr))                                   return 1'b1;
    if (op_is_write(op) && (last >= {1'b0, FIXED_BASE}))  return 1'b1;
    return 1'b0;
  endfunction

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [2:0]        op_q, op_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wlo_q, wlo_d;
  logic [DATA_W-1:0] rhi_q, rhi_d;
  logic [DATA_W-1:0] rlo_q, rlo_d;
  logic [2:0]        ebank_q, ebank_d;
  logic [4:0]        fbank_q, fbank_d;
  logic              super_q, super_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;

  logic accept;
  logic req_bad;
  logic in_access;

  assign accept  = req_valid && req_ready;
  assign req_bad = req_illegal(req_op, req_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      op_q    <= '0;
      err_q   <= 1'b0;
      wlo_q   <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      ebank_q <= '0;
      fbank_q <= '0;
      super_q <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wlo_q   <= wlo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      ebank_q <= ebank_d;
      fbank_q <= fbank_d;
      super_q <= super_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    op_d    = op_q;
    err_d   = err_q;
    wlo_d   = wlo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    ebank_d = ebank_q;
    fbank_d = fbank_q;
    super_d = super_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          err_d = req_bad;
          rhi_d = '0;
          rlo_d = '0;
          // Rejected requests never touch the memory port, which keeps its last values.
          if (req_bad) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACC_HI;
            wlo_d   = req_wdata_lo;
            ebank_d = req_ebank;
            fbank_d = req_fbank;
            super_d = req_super;
            maddr_d = req_addr;
            mdata_d = req_wdata_hi;
          end
        end
      end
      ST_ACC_HI: begin
        // The read is combinational, so this is the pre-write value for exchanges.
        rhi_d = mem_result;
        if (op_is_double(op_q)) begin
          state_d = ST_ACC_LO;
          maddr_d = maddr_q + ADDR_W'(1);
          mdata_d = wlo_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_ACC_LO: begin
        rlo_d   = mem_result;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write strobe comes straight from the state register so reset kills it at once.
  assign in_access        = (state_q == ST_ACC_HI) || (state_q == ST_ACC_LO);
  assign mem_write_enable = in_access && op_is_write(op_q);

  assign req_ready    = rdy_q && (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_err      = err_q;
  assign rsp_rdata_hi = rhi_q;
  assign rsp_rdata_lo = rlo_q;
  assign mem_ebank    = ebank_q;
  assign mem_fbank    = fbank_q;
  assign mem_super    = super_q;
  assign mem_address  = maddr_q;
  assign mem_data_out = mdata_q;

endmodule
